// File: rtl/neureka_package.sv
// rtl/neureka_package.sv - shared types and defaults for the binconv PE accumulator
package neureka_package;

  localparam int N_COL_DEF  = 4;
  localparam int COL_W_DEF  = 22;
  localparam int PASS_W_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    EMIT  = 2'd2
  } state_e;

  // Accumulator width: lane growth from the N_COL reduction plus up to 2^PASS_W beats.
  function automatic int out_width(input int n_col, input int col_w, input int pass_w);
    return col_w + $clog2(n_col) + pass_w;
  endfunction

endpackage

// File: rtl/neureka_binconv_pe_accum_if.sv
// rtl/neureka_binconv_pe_accum_if.sv - column input stream and pointwise/depthwise output streams
interface neureka_binconv_pe_accum_if
  import neureka_package::*;
#(
  parameter int N_COL = N_COL_DEF,
  parameter int COL_W = COL_W_DEF,
  parameter int OUT_W = out_width(N_COL_DEF, COL_W_DEF, PASS_W_DEF)
);

  logic                   col_valid_i;
  logic                   col_ready_o;
  logic [N_COL*COL_W-1:0] col_data_i;
  logic [N_COL-1:0]       col_en_i;
  logic                   pw_valid_o;
  logic                   pw_ready_i;
  logic [OUT_W-1:0]       pw_data_o;
  logic                   dw_valid_o;
  logic                   dw_ready_i;
  logic [N_COL*OUT_W-1:0] dw_data_o;

  modport slave (
    input  col_valid_i, col_data_i, col_en_i, pw_ready_i, dw_ready_i,
    output col_ready_o, pw_valid_o, pw_data_o, dw_valid_o, dw_data_o
  );

  modport master (
    output col_valid_i, col_data_i, col_en_i, pw_ready_i, dw_ready_i,
    input  col_ready_o, pw_valid_o, pw_data_o, dw_valid_o, dw_data_o
  );

endinterface

// File: rtl/neureka_accum_lane.sv
// rtl/neureka_accum_lane.sv - one column lane: mask, sign-extend and accumulate
module neureka_accum_lane
  import neureka_package::*;
#(
  parameter int COL_W = COL_W_DEF,
  parameter int OUT_W = out_width(N_COL_DEF, COL_W_DEF, PASS_W_DEF)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             load_i,
  input  logic             first_i,
  input  logic             en_i,
  input  logic [COL_W-1:0] data_i,
  output logic [OUT_W-1:0] ext_o,
  output logic [OUT_W-1:0] sum_o
);

  logic [OUT_W-1:0] acc_q, acc_d;

  assign ext_o = en_i ? {{(OUT_W-COL_W){data_i[COL_W-1]}}, data_i} : '0;

  // The first beat of a group starts from zero rather than the stale group total.
  assign sum_o = (first_i ? '0 : acc_q) + ext_o;

  always_comb begin
    acc_d = acc_q;
    if (clear_i) begin
      acc_d = '0;
    end else if (load_i) begin
      acc_d = sum_o;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/neureka_binconv_pe_accum.sv
// rtl/neureka_binconv_pe_accum.sv - binconv PE accumulator with pointwise reduce and depthwise per-lane outputs
module neureka_binconv_pe_accum
  import neureka_package::*;
#(
  parameter  int N_COL  = N_COL_DEF,
  parameter  int COL_W  = COL_W_DEF,
  parameter  int PASS_W = PASS_W_DEF,
  localparam int OUT_W  = out_width(N_COL, COL_W, PASS_W)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    clear_i,
  input  logic                    enable_i,
  input  logic                    mode_dw_i,
  input  logic [PASS_W-1:0]       n_pass_i,
  input  logic [OUT_W-1:0]        padding_i,
  output logic                    busy_o,
  neureka_binconv_pe_accum_if.slave bus
);

  state_e                      state_q, state_d;
  logic                        in_group_q, in_group_d;
  logic [PASS_W-1:0]           cnt_q, cnt_d;
  logic [PASS_W-1:0]           npass_q, npass_d;
  logic                        mode_q, mode_d;
  logic [OUT_W-1:0]            pw_acc_q, pw_acc_d;
  logic                        pw_valid_q, pw_valid_d;
  logic                        dw_valid_q, dw_valid_d;
  logic [OUT_W-1:0]            pw_data_q, pw_data_d;
  logic [N_COL-1:0][OUT_W-1:0] dw_data_q, dw_data_d;

  logic                        first_beat, mode_eff, final_beat;
  logic [PASS_W-1:0]           npass_eff;
  logic                        out_pend, out_fire, cur_ready, col_ready, accept;
  logic [N_COL-1:0][OUT_W-1:0] lane_ext, lane_sum;
  logic [OUT_W-1:0]            pw_beat, pw_sum;

  // The first beat of a group sees its own mode/length; later beats use the latched copy.
  assign first_beat = !in_group_q;
  assign mode_eff   = first_beat ? mode_dw_i : mode_q;
  assign npass_eff  = first_beat ? n_pass_i : npass_q;
  assign final_beat = (cnt_q == npass_eff);

  assign out_pend  = pw_valid_q | dw_valid_q;
  assign out_fire  = (pw_valid_q & bus.pw_ready_i) | (dw_valid_q & bus.dw_ready_i);
  assign cur_ready = pw_valid_q ? bus.pw_ready_i : bus.dw_ready_i;

  // A final beat may only land when the output register is free or draining this cycle.
  assign col_ready = !(final_beat && out_pend && !cur_ready);
  assign accept    = bus.col_valid_i && col_ready && !clear_i;

  for (genvar k = 0; k < N_COL; k++) begin : g_lane
    neureka_accum_lane #(
      .COL_W (COL_W),
      .OUT_W (OUT_W)
    ) u_lane (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .clear_i (clear_i),
      .load_i  (accept),
      .first_i (first_beat),
      .en_i    (bus.col_en_i[k]),
      .data_i  (bus.col_data_i[k*COL_W +: COL_W]),
      .ext_o   (lane_ext[k]),
      .sum_o   (lane_sum[k])
    );
  end

  always_comb begin
    pw_beat = '0;
    for (int k = 0; k < N_COL; k++) begin
      pw_beat = pw_beat + lane_ext[k];
    end
  end

  assign pw_sum = (first_beat ? '0 : pw_acc_q) + pw_beat;

  always_comb begin
    in_group_d = in_group_q;
    cnt_d      = cnt_q;
    mode_d     = mode_q;
    npass_d    = npass_q;
    pw_acc_d   = pw_acc_q;
    if (accept) begin
      if (first_beat) begin
        mode_d  = mode_dw_i;
        npass_d = n_pass_i;
      end
      in_group_d = !final_beat;
      cnt_d      = final_beat ? '0 : cnt_q + 1'b1;
      pw_acc_d   = pw_sum;
    end
    if (clear_i) begin
      in_group_d = 1'b0;
      cnt_d      = '0;
      pw_acc_d   = '0;
    end
  end

  always_comb begin
    pw_valid_d = pw_valid_q;
    dw_valid_d = dw_valid_q;
    pw_data_d  = pw_data_q;
    dw_data_d  = dw_data_q;
    if (pw_valid_q && bus.pw_ready_i) pw_valid_d = 1'b0;
    if (dw_valid_q && bus.dw_ready_i) dw_valid_d = 1'b0;
    if (accept && final_beat) begin
      if (mode_eff) begin
        dw_valid_d = 1'b1;
        for (int k = 0; k < N_COL; k++) begin
          dw_data_d[k] = enable_i ? lane_sum[k] : padding_i;
        end
      end else begin
        pw_valid_d = 1'b1;
        pw_data_d  = enable_i ? pw_sum : padding_i;
      end
    end
    if (clear_i) begin
      pw_valid_d = 1'b0;
      dw_valid_d = 1'b0;
      pw_data_d  = '0;
      dw_data_d  = '0;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = final_beat ? EMIT : ACCUM;
      ACCUM:   if (accept && final_beat) state_d = EMIT;
      EMIT: begin
        if (accept && final_beat) begin
          state_d = EMIT;
        end else if (out_fire) begin
          state_d = (in_group_q || accept) ? ACCUM : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (clear_i) state_d = IDLE;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      in_group_q <= 1'b0;
      cnt_q      <= '0;
      npass_q    <= '0;
      mode_q     <= 1'b0;
      pw_acc_q   <= '0;
      pw_valid_q <= 1'b0;
      dw_valid_q <= 1'b0;
      pw_data_q  <= '0;
      dw_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      in_group_q <= in_group_d;
      cnt_q      <= cnt_d;
      npass_q    <= npass_d;
      mode_q     <= mode_d;
      pw_acc_q   <= pw_acc_d;
      pw_valid_q <= pw_valid_d;
      dw_valid_q <= dw_valid_d;
      pw_data_q  <= pw_data_d;
      dw_data_q  <= dw_data_d;
    end
  end

  assign bus.col_ready_o = col_ready;
  assign bus.pw_valid_o  = pw_valid_q;
  assign bus.pw_data_o   = pw_data_q;
  assign bus.dw_valid_o  = dw_valid_q;
  assign bus.dw_data_o   = dw_data_q;
  assign busy_o          = (state_q != IDLE);

endmodule
